// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bundle: raw buttons in,
// run/tick/scan/clear/hold/state out.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       run_en;
  logic       tick_100;
  logic       scan_tick;
  logic       clr;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    input  btn_start, btn_lap,
    output run_en, tick_100, scan_tick,
    output clr, lap_hold, state
  );

  modport slave (
    output btn_start, btn_lap,
    input  run_en, tick_100, scan_tick,
    input  clr, lap_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button sync/edge detect,
// IDLE/RUN/PAUSE/LAP FSM, count and scan prescalers.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 50000
) (
  input logic clk,
  input logic reset,
  stopwatch_ctrl_if.master sw
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // bit 0 = start, bit 1 = lap
  logic [1:0] sync1, sync2, prev;
  logic [1:0] press;
  logic       start_p, lap_p;

  state_t     st, nxt;
  logic       clr_d, tzero;
  logic       running, adv, tick;
  logic       run_q, hold_q, clr_q;

  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic          scan_hit;

  // two-flop synchroniser plus previous-level register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {sw.btn_lap, sw.btn_start};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press   = sync2 & ~prev;
  assign start_p = press[0];
  assign lap_p   = press[1] & ~press[0];

  // next state; start outranks lap on a tie
  always_comb begin
    nxt   = st;
    clr_d = 1'b0;
    tzero = 1'b0;
    unique case (st)
      IDLE: begin
        if (start_p) begin
          nxt   = RUN;
          tzero = 1'b1;
        end
      end
      RUN: begin
        if (start_p)    nxt = PAUSE;
        else if (lap_p) nxt = LAP;
      end
      LAP: begin
        if (start_p)    nxt = PAUSE;
        else if (lap_p) nxt = RUN;
      end
      PAUSE: begin
        if (start_p) begin
          nxt = RUN;
        end else if (lap_p) begin
          nxt   = IDLE;
          clr_d = 1'b1;
          tzero = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // prescaler only advances when staying in a running state,
  // so the leaving cycle neither ticks nor loses its count
  assign running = (st == RUN) || (st == LAP);
  assign adv     = running && ((nxt == RUN) || (nxt == LAP));
  assign tick    = adv && (tcnt == TW'(TICK_DIV - 1));

  // state and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= IDLE;
      run_q  <= 1'b0;
      hold_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      st     <= nxt;
      run_q  <= (nxt == RUN) || (nxt == LAP);
      hold_q <= (nxt == LAP);
      clr_q  <= clr_d;
    end
  end

  // centisecond prescaler, held through PAUSE
  always_ff @(posedge clk) begin
    if (reset)      tcnt <= '0;
    else if (tzero) tcnt <= '0;
    else if (adv)   tcnt <= tick ? '0 : tcnt + TW'(1);
  end

  assign scan_hit = (scnt == SW'(SCAN_DIV - 1));

  // free-running digit scan prescaler
  always_ff @(posedge clk) begin
    if (reset) scnt <= '0;
    else       scnt <= scan_hit ? '0 : scnt + SW'(1);
  end

  assign sw.state     = st;
  assign sw.run_en    = run_q;
  assign sw.lap_hold  = hold_q;
  assign sw.clr       = clr_q;
  assign sw.tick_100  = tick;
  assign sw.scan_tick = scan_hit;
endmodule
